// File: rtl/led_io_ctrl.sv
// LED/switch/button peripheral on an Avalon-MM slave: four LED modes,
// synchronised switches, debounced buttons with sticky press flags and IRQ.
module led_io_ctrl #(
    parameter int N_LEDS          = 8,
    parameter int N_SW            = 8,
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DEFAULT_PERIOD  = 25000000
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [2:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              irq,
    input  logic [N_SW-1:0]   switches,
    input  logic [N_BTN-1:0]  buttons,
    output logic [N_LEDS-1:0] leds
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_ROTATE = 2'd2;
    localparam logic [1:0] MODE_MIRROR = 2'd3;

    logic                        r_en;
    logic [1:0]                  r_mode;
    logic [N_LEDS-1:0]           r_led_val;
    logic [31:0]                 r_period;
    logic [N_BTN-1:0]            r_edge;
    logic [N_BTN-1:0]            r_mask;
    logic [N_SW-1:0]             r_sw_s1;
    logic [N_SW-1:0]             r_sw_s2;
    logic [N_BTN-1:0]            r_btn_s1;
    logic [N_BTN-1:0]            r_btn_s2;
    logic [N_BTN-1:0]            r_btn;
    logic [N_BTN-1:0]            r_btn_prev;
    logic [N_BTN-1:0][DB_W-1:0]  r_db_cnt;
    logic [31:0]                 r_cnt;
    logic                        r_phase;
    logic [N_LEDS-1:0]           r_shift;
    logic [N_LEDS-1:0]           r_leds;
    logic                        r_irq;
    logic [31:0]                 r_rdata;

    logic              w_wr_ctrl;
    logic              w_wr_led;
    logic              w_wr_period;
    logic              w_wr_edge;
    logic              w_wr_mask;
    logic [N_BTN-1:0]  w_w1c;
    logic [N_BTN-1:0]  w_raw;
    logic [N_BTN-1:0]  w_press;
    logic [31:0]       w_per_m1;
    logic              w_clr;
    logic              w_tick;
    logic [N_LEDS-1:0] w_rotl;
    logic [N_LEDS-1:0] w_mirror;
    logic [N_LEDS-1:0] w_leds_nxt;
    logic [31:0]       w_rdata;

    assign w_wr_ctrl   = avs_write && (avs_address == 3'd0);
    assign w_wr_led    = avs_write && (avs_address == 3'd1);
    assign w_wr_period = avs_write && (avs_address == 3'd2);
    assign w_wr_edge   = avs_write && (avs_address == 3'd5);
    assign w_wr_mask   = avs_write && (avs_address == 3'd6);
    assign w_w1c       = w_wr_edge ? avs_writedata[N_BTN-1:0] : '0;

    // Buttons are active-low on the pins; internally 1 = pressed
    assign w_raw   = ~r_btn_s2;
    assign w_press = r_btn & ~r_btn_prev;

    assign w_per_m1 = (r_period == 32'd0) ? 32'd0 : r_period - 32'd1;
    assign w_clr    = w_wr_ctrl || w_wr_period;
    assign w_tick   = r_en && !w_clr && (r_cnt == w_per_m1);
    assign w_rotl   = (r_shift << 1) | (r_shift >> (N_LEDS - 1));

    generate
        if (N_LEDS <= N_SW) begin : g_mir_trunc
            assign w_mirror = r_sw_s2[N_LEDS-1:0];
        end else begin : g_mir_ext
            assign w_mirror = {{(N_LEDS - N_SW){1'b0}}, r_sw_s2};
        end
    endgenerate

    always_comb begin
        w_leds_nxt = '0;
        if (r_en) begin
            unique case (r_mode)
                MODE_STATIC: w_leds_nxt = r_led_val;
                MODE_BLINK:  w_leds_nxt = r_phase ? r_led_val : '0;
                MODE_ROTATE: w_leds_nxt = r_shift;
                MODE_MIRROR: w_leds_nxt = w_mirror;
                default:     w_leds_nxt = '0;
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        unique case (avs_address)
            3'd0:    w_rdata = {29'd0, r_mode, r_en};
            3'd1:    w_rdata = 32'(r_led_val);
            3'd2:    w_rdata = r_period;
            3'd3:    w_rdata = 32'(r_sw_s2);
            3'd4:    w_rdata = 32'(r_btn);
            3'd5:    w_rdata = 32'(r_edge);
            3'd6:    w_rdata = 32'(r_mask);
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_en      <= 1'b0;
            r_mode    <= MODE_STATIC;
            r_led_val <= '0;
            r_period  <= 32'(DEFAULT_PERIOD);
            r_mask    <= '0;
            r_edge    <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_en   <= avs_writedata[0];
                r_mode <= avs_writedata[2:1];
            end
            if (w_wr_led)    r_led_val <= avs_writedata[N_LEDS-1:0];
            if (w_wr_period) r_period  <= avs_writedata;
            if (w_wr_mask)   r_mask    <= avs_writedata[N_BTN-1:0];
            // A new press in the clear cycle survives the W1C
            r_edge <= (r_edge & ~w_w1c) | w_press;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sw_s1    <= '0;
            r_sw_s2    <= '0;
            r_btn_s1   <= '1;
            r_btn_s2   <= '1;
            r_btn      <= '0;
            r_btn_prev <= '0;
            r_db_cnt   <= '0;
        end else begin
            r_sw_s1    <= switches;
            r_sw_s2    <= r_sw_s1;
            r_btn_s1   <= buttons;
            r_btn_s2   <= r_btn_s1;
            r_btn_prev <= r_btn;
            for (int i = 0; i < N_BTN; i++) begin
                if (w_raw[i] != r_btn[i]) begin
                    if (r_db_cnt[i] == DB_MAX) begin
                        r_btn[i]    <= w_raw[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_shift <= '0;
            r_leds  <= '0;
            r_irq   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_clr || !r_en || w_tick) r_cnt <= '0;
            else                          r_cnt <= r_cnt + 32'd1;
            if (w_wr_ctrl) begin
                r_phase <= 1'b1;
                r_shift <= r_led_val;
            end else if (w_wr_led) begin
                r_shift <= avs_writedata[N_LEDS-1:0];
            end else if (w_tick) begin
                if (r_mode == MODE_BLINK)  r_phase <= ~r_phase;
                if (r_mode == MODE_ROTATE) r_shift <= w_rotl;
            end
            r_leds <= w_leds_nxt;
            r_irq  <= |(r_edge & r_mask);
            if (avs_read) r_rdata <= w_rdata;
        end
    end

    assign leds         = r_leds;
    assign irq          = r_irq;
    assign avs_readdata = r_rdata;

endmodule

// File: tb/tb_led_io_ctrl.sv
// Directed bench for led_io_ctrl: register table plus hand-timed
// sequences for blink, rotate, debounce, edge collision and reset.
module tb_led_io_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;
    logic [7:0]  switches;
    logic [3:0]  buttons;
    logic [7:0]  leds;

    int n_chk = 0;
    int n_err = 0;

    led_io_ctrl #(
        .N_LEDS(8), .N_SW(8), .N_BTN(4),
        .DEBOUNCE_CYCLES(8), .DEFAULT_PERIOD(25000000)
    ) dut (
        .clk_clk(clk),
        .reset_reset_n(rst_n),
        .avs_address(avs_address),
        .avs_read(avs_read),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata),
        .irq(irq),
        .switches(switches),
        .buttons(buttons),
        .leds(leds)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vt[11];
    logic [7:0] rot_exp[9];
    logic [31:0] d;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Both tasks start and end on a falling edge
    task automatic wr(input logic [2:0] a, input logic [31:0] dat);
        avs_address = a;
        avs_writedata = dat;
        avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] dat);
        avs_address = a;
        avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        dat = avs_readdata;
    endtask

    initial begin
        vt[0]  = '{3'd1, 32'h0000_01A5, 32'h0000_00A5, "ledval_trunc"};
        vt[1]  = '{3'd6, 32'hFFFF_FFFF, 32'h0000_000F, "mask_trunc"};
        vt[2]  = '{3'd0, 32'hFFFF_FFF8, 32'h0000_0000, "ctrl_hibits"};
        vt[3]  = '{3'd0, 32'h0000_0005, 32'h0000_0005, "ctrl_rw"};
        vt[4]  = '{3'd2, 32'h1234_5678, 32'h1234_5678, "period_rw"};
        vt[5]  = '{3'd3, 32'h0000_00FF, 32'h0000_0000, "sw_ro"};
        vt[6]  = '{3'd4, 32'h0000_000F, 32'h0000_0000, "btn_ro"};
        vt[7]  = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0000, "addr7"};
        vt[8]  = '{3'd5, 32'h0000_000F, 32'h0000_0000, "edge_w1c_idle"};
        vt[9]  = '{3'd0, 32'h0000_0000, 32'h0000_0000, "ctrl_off"};
        vt[10] = '{3'd6, 32'h0000_0000, 32'h0000_0000, "mask_off"};
        rot_exp = '{8'h81, 8'h03, 8'h06, 8'h0C, 8'h18,
                    8'h30, 8'h60, 8'hC0, 8'h81};

        rst_n = 1'b0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        switches = 8'($urandom);
        buttons = 4'($urandom);
        repeat (3) @(negedge clk);
        chk("rst_leds", 32'(leds), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_rdata", avs_readdata, 32'h0);
        switches = 8'h00;
        buttons = 4'hF;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            chk($sformatf("rst_reg%0d", a), d,
                (a == 2) ? 32'd25000000 : 32'd0);
        end

        for (int i = 0; i < 11; i++) begin
            wr(vt[i].addr, vt[i].wdata);
            rd(vt[i].addr, d);
            chk(vt[i].name, d, vt[i].exp);
        end

        avs_address = 3'd1;
        avs_writedata = 32'h3C;
        avs_write = 1'b1;
        avs_read = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
        avs_read = 1'b0;
        chk("rw_same_old", avs_readdata, 32'hA5);
        rd(3'd1, d);
        chk("rw_same_new", d, 32'h3C);

        wr(3'd2, 32'd4);
        wr(3'd1, 32'hA5);
        wr(3'd0, 32'h3);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("blink4_%0d", k), 32'(leds),
                (((k - 1) / 4) % 2 == 0) ? 32'hA5 : 32'h0);
        end
        wr(3'd2, 32'd0);
        wr(3'd0, 32'h3);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("blink0_%0d", k), 32'(leds),
                (k % 2 == 1) ? 32'hA5 : 32'h0);
        end

        wr(3'd1, 32'h81);
        wr(3'd2, 32'd2);
        wr(3'd0, 32'h5);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            chk($sformatf("rot_%0d", k), 32'(leds),
                32'(rot_exp[(k - 1) / 2]));
        end
        wr(3'd1, 32'h01);
        @(negedge clk);
        chk("rot_reload", 32'(leds), 32'h01);
        repeat (2) @(negedge clk);
        chk("rot_after_reload", 32'(leds), 32'h02);
        wr(3'd0, 32'h0);
        @(negedge clk);
        chk("en_off_leds", 32'(leds), 32'h0);

        buttons = 4'b1011;
        repeat (5) @(negedge clk);
        buttons = 4'hF;
        repeat (12) @(negedge clk);
        rd(3'd4, d);
        chk("bounce_btn", d, 32'h0);
        rd(3'd5, d);
        chk("bounce_edge", d, 32'h0);

        buttons = 4'b1011;
        repeat (9) @(negedge clk);
        rd(3'd4, d);
        chk("btn_early", d, 32'h0);
        rd(3'd4, d);
        chk("btn_press", d, 32'h4);
        rd(3'd5, d);
        chk("edge_set", d, 32'h4);
        wr(3'd6, 32'h4);
        chk("irq_lat", 32'(irq), 32'h0);
        @(negedge clk);
        chk("irq_set", 32'(irq), 32'h1);
        wr(3'd5, 32'h4);
        @(negedge clk);
        chk("irq_clr", 32'(irq), 32'h0);
        rd(3'd5, d);
        chk("edge_clr", d, 32'h0);
        buttons = 4'hF;
        repeat (12) @(negedge clk);
        rd(3'd4, d);
        chk("btn_release", d, 32'h0);
        rd(3'd5, d);
        chk("edge_release", d, 32'h0);

        buttons = 4'b1110;
        repeat (10) @(negedge clk);
        wr(3'd5, 32'h1);
        rd(3'd5, d);
        chk("edge_collide", d, 32'h1);
        chk("irq_unmasked_bit", 32'(irq), 32'h0);
        buttons = 4'hF;
        wr(3'd6, 32'h1);
        @(negedge clk);
        chk("irq_bit0", 32'(irq), 32'h1);

        wr(3'd0, 32'h7);
        switches = 8'h3C;
        repeat (2) @(negedge clk);
        chk("mirror_early", 32'(leds), 32'h0);
        @(negedge clk);
        chk("mirror_leds", 32'(leds), 32'h3C);
        rd(3'd3, d);
        chk("sw_reg", d, 32'h3C);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_leds", 32'(leds), 32'h0);
        chk("midrst_irq", 32'(irq), 32'h0);
        chk("midrst_rdata", avs_readdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(3'd0, d);
        chk("midrst_ctrl", d, 32'h0);
        rd(3'd1, d);
        chk("midrst_ledval", d, 32'h0);
        rd(3'd2, d);
        chk("midrst_period", d, 32'd25000000);
        rd(3'd5, d);
        chk("midrst_edge", d, 32'h0);
        rd(3'd6, d);
        chk("midrst_mask", d, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/led_io_ctrl.md
# led_io_ctrl

Parametrised LED/switch/push-button peripheral that is the successor to the fixed 8-LED/8-switch/4-button blinker in the FPGA side of the HPS–FPGA system. It sits on the lightweight HPS-to-FPGA bridge as an Avalon-MM slave and drives N LEDs in one of four modes: static, blink, rotate, or switch-mirror. It synchronises switches, debounces buttons, latches button presses into sticky edge flags, and raises a maskable level interrupt to the HPS.

## Interface
- N_LEDS, 8, LED output count (1..32)
- N_SW, 8, switch input count (1..32)
- N_BTN, 4, button input count (1..32)
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles before a button change is accepted (>=2)
- DEFAULT_PERIOD, 25000000, reset value of PERIOD

Ports:
- clk_clk  in  1  sole clock; every flop is on its rising edge.
- reset_reset_n  in  1  asynchronous, active-low reset.
- avs_address  in  3  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data; fixed read latency 1.
- irq  out  1  level interrupt, active high.
- switches  in  N_SW  raw asynchronous switch inputs.
- buttons  in  N_BTN  raw asynchronous buttons, active-low (0 = pressed).
- leds  out  N_LEDS  LED drive, active-high.

## Operation
Register map (word address, bits):
- 0 CTRL, RW: [0] EN; [2:1] MODE (0 static, 1 blink, 2 rotate, 3 mirror).
- 1 LED_VAL, RW: [N_LEDS-1:0].
- 2 PERIOD, RW: 32-bit tick period in clocks. Value 0 behaves as 1.
- 3 SW, RO: synchronised switches.
- 4 BTN, RO: debounced button state, 1 = pressed.
- 5 EDGE, RW1C: sticky press flags, one per button.
- 6 IRQ_MASK, RW: [N_BTN-1:0].
- 7: reads 0; writes are ignored. Unused high bits read 0.

Input and button handling:
- switches and buttons each pass through a 2-FF synchroniser.
- Per-button debounce: a counter increments while the synchronised raw value differs from the stable value. It clears whenever they match. When the count reaches DEBOUNCE_CYCLES-1, the stable value updates and the counter clears.
- A press is a 0->1 transition of BTN. It sets the corresponding EDGE bit.
- irq = |(EDGE & IRQ_MASK), driven as a registered output.

Tick counter:
- Counts 0..PERIOD-1. A tick pulses for one cycle when the counter is at PERIOD-1, and the counter then wraps to 0.
- The counter is held at 0 when EN=0.
- A write to PERIOD or CTRL clears the counter.

LED modes (leds is registered):
- EN=0: leds=0.
- Static: leds=LED_VAL.
- Blink: phase starts at 1 on entry and toggles each tick; leds = phase ? LED_VAL : 0.
- Rotate: a shift register loads LED_VAL on entry to the mode and on any LED_VAL write. Each tick rotates it left by 1, with bit N_LEDS-1 wrapping to bit 0. leds = shift register.
- Mirror: leds = SW, zero-extended or truncated to N_LEDS.
- "Entry" means a CTRL write that leaves EN=1 with this MODE, including a rewrite of the same value.

Boundary rules:
- Simultaneous EDGE set and W1C on the same bit: set wins.
- Write to a RO register: ignored.
- Simultaneous read and write to the same address: readdata returns the old value.
- Reset asserted mid-operation: all state returns to its reset values immediately, regardless of clock. This includes debounce counters, synchronisers, and shift/phase.

## Timing
Reset values:
- leds=0, irq=0, avs_readdata=0.
- CTRL=0, LED_VAL=0, PERIOD=DEFAULT_PERIOD, EDGE=0, IRQ_MASK=0.
- Synchronisers reset to 0 for switches and to 1 (released) for buttons. BTN=0.

Latencies:
- Read: avs_readdata is valid in the cycle after avs_read; it holds its value otherwise.
- Write: the register updates on the strobe edge. leds reflects a CTRL or LED_VAL change 1 cycle later.
- Switch to SW/leds (mirror mode): 3 cycles (2 sync + 1 register).
- Button release-to-press: stable after 2 + DEBOUNCE_CYCLES cycles. EDGE set 1 cycle later; irq 1 cycle after that.
- Tick: first tick occurs PERIOD cycles after the counter clears. Blink and rotate then update leds 1 cycle after the tick.
- No wait states. Writes complete in 1 cycle.

## Test plan
- Reset: hold reset_reset_n=0 with random inputs -> leds=0, irq=0, PERIOD reads 25000000, all other registers read 0.
- Blink: PERIOD=4, LED_VAL=0xA5, CTRL=0x3 -> leds alternates 0xA5/0x00 every 4 cycles. PERIOD=0 -> toggles every cycle.
- Rotate: LED_VAL=0x81, PERIOD=2, CTRL=0x5 -> leds sequence 0x81, 0x03, 0x06, … with MSB wrapping. Rewrite LED_VAL=0x01 mid-run -> reloads 0x01.
- Debounce (DEBOUNCE_CYCLES=8): button 2 bounces low for 5 cycles then high -> BTN unchanged, EDGE=0. Held low 8+ cycles -> BTN=0x4, EDGE=0x4. With IRQ_MASK=0x4 -> irq=1; W1C 0x4 -> irq=0.
- Collision: new press on button 0 in the same cycle as a W1C of EDGE bit 0 -> EDGE[0] stays 1.
- Mirror plus reset mid-op: CTRL=0x7, switches=0x3C -> leds=0x3C after 3 cycles. Assert reset mid-period -> leds=0 immediately.
